rn_recover_seq: RTL and testbench
=================================

// Module: rn_recover_seq
// PURPOSE
//   Sequences rename-state recovery after a pipeline flush.
//   Drains in-flight commits, then walks the committed (architectural) RAT and copies it
//   into the speculative RAT, 2^CONFIG_P_RECOVER_WIDTH entries per cycle.
//   Then pulses a free-list re-init and releases the rename stage.
//   Sits beside the rename stage; its stall request is ORed into the rename stall.
// PARAMETERS
//   CONFIG_P_RECOVER_WIDTH  1  log2 of RAT entries restored per cycle (W = 1<<P); must be <= CONFIG_LRF_AW
//   CONFIG_LRF_AW           5  logical register address width (N = 1<<CONFIG_LRF_AW entries)
//   CONFIG_PRF_AW           6  physical register address width
// PORTS
//   clk             in   1          clock
//   rst             in   1          synchronous active-high reset
//   flush           in   1          pipeline flush request (level, sampled every cycle)
//   cmt_pending     in   1          commit still retiring older instrs; arch RAT not final
//   arat_raddr      out  W*LRF_AW   arch-RAT read addresses, slot i = base+i
//   arat_rdata      in   W*PRF_AW   arch-RAT read data, combinational, same cycle
//   srat_waddr      out  W*LRF_AW   spec-RAT write addresses (equal to arat_raddr)
//   srat_wdata      out  W*PRF_AW   spec-RAT write data (= arat_rdata)
//   srat_we         out  W          spec-RAT write enables
//   fl_reinit       out  1          one-cycle pulse: free list rebuilds from arch state
//   rec_done        out  1          one-cycle pulse: recovery complete
//   rec_stall_req   out  1          stall rename/issue while recovering
// BEHAVIOUR
//   Registered state: 2-bit FSM {IDLE, DRAIN, WALK, DONE}; group pointer gp, width LRF_AW-P.
//   Reset: state=IDLE, gp=0.
//     All outputs 0: arat_raddr, srat_waddr and srat_wdata are driven 0 outside WALK.
//   Transitions (flush has priority over every other condition, in every state):
//   - IDLE: flush -> DRAIN, gp<=0.
//   - DRAIN: flush -> DRAIN, gp<=0.
//       Else cmt_pending=0 -> WALK. Else stay. Minimum one cycle in DRAIN.
//   - WALK: flush -> DRAIN, gp<=0; no write is suppressed in the flush cycle.
//       Else if gp == N/W-1 -> DONE, gp<=0.
//       Else gp<=gp+1.
//   - DONE: flush -> DRAIN, gp<=0; fl_reinit and rec_done forced 0 in this case.
//       Else -> IDLE.
//   WALK outputs (combinational from state/gp):
//     slot i address = {gp,i[P-1:0]}; srat_wdata slot i = arat_rdata slot i; srat_we = all ones.
//   srat_we = 0 in all other states.
//   DONE outputs: fl_reinit = rec_done = 1 for exactly one cycle (unless flush).
//   rec_stall_req = flush | (state != IDLE). Combinational, so asserted in the flush cycle itself.
//   Latency, flush at cycle t with cmt_pending=0:
//     DRAIN at t+1; WALK at t+2 .. t+1+N/W; DONE at t+2+N/W; IDLE at t+3+N/W.
//   gp wraps only via explicit reset to 0; no overflow past N/W-1.
//   Logical r0 is written like any other entry; no skip.
//   cmt_pending is ignored outside DRAIN.
// TESTING
//   1. rst held 2 cycles, then released with flush=0
//      -> state IDLE; srat_we=0, fl_reinit=0, rec_done=0, rec_stall_req=0.
//   2. P=1, N=32, flush pulse at t=0, cmt_pending=0, arch RAT preloaded entry k = k+32
//      -> srat_we=2'b11 at t=2..17; addrs {1,0}..{31,30}.
//      -> spec RAT equals arch RAT; fl_reinit and rec_done at t=18; stall drops at t=19.
//   3. flush at t=0, cmt_pending=1 for t=0..5
//      -> DRAIN held through t=6; first srat_we at t=7; rec_stall_req=1 throughout.
//   4. flush re-asserted in WALK while gp=7
//      -> next cycle DRAIN, gp=0; a full 16 groups are rewritten from addr 0; single fl_reinit at end.
//   5. rst asserted mid-WALK (gp=5)
//      -> next cycle IDLE; srat_we=0; no fl_reinit/rec_done pulse; rec_stall_req=0.
//   6. P=0, N=32, flush with cmt_pending=0
//      -> 32 WALK cycles, srat_we=1'b1, addrs 0..31; DONE at t=34.
//   7. flush asserted exactly in the DONE cycle
//      -> fl_reinit=0, rec_done=0; FSM re-enters DRAIN; a full walk repeats.

Source files
------------

// File: rtl/rn_recover_seq.sv
// Rename-state recovery sequencer: after a flush, waits for commit to drain, copies the
// architectural RAT into the speculative RAT W entries per cycle, then pulses free-list re-init.
module rn_recover_seq #(
  parameter int CONFIG_P_RECOVER_WIDTH = 1,
  parameter int CONFIG_LRF_AW          = 5,
  parameter int CONFIG_PRF_AW          = 6
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic                                                  flush,
  input  logic                                                  cmt_pending,
  output logic [(1<<CONFIG_P_RECOVER_WIDTH)*CONFIG_LRF_AW-1:0]  arat_raddr,
  input  logic [(1<<CONFIG_P_RECOVER_WIDTH)*CONFIG_PRF_AW-1:0]  arat_rdata,
  output logic [(1<<CONFIG_P_RECOVER_WIDTH)*CONFIG_LRF_AW-1:0]  srat_waddr,
  output logic [(1<<CONFIG_P_RECOVER_WIDTH)*CONFIG_PRF_AW-1:0]  srat_wdata,
  output logic [(1<<CONFIG_P_RECOVER_WIDTH)-1:0]                srat_we,
  output logic                                                  fl_reinit,
  output logic                                                  rec_done,
  output logic                                                  rec_stall_req
);

  localparam int P   = CONFIG_P_RECOVER_WIDTH;
  localparam int LAW = CONFIG_LRF_AW;
  localparam int PAW = CONFIG_PRF_AW;
  localparam int W   = 1 << P;
  // Keep the pointer at least one bit wide when a single group covers the whole RAT.
  localparam int GPW = (LAW > P) ? (LAW - P) : 1;
  localparam logic [GPW-1:0] GP_LAST = GPW'((1 << (LAW - P)) - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_WALK  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [GPW-1:0] gp_q, gp_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      gp_q    <= '0;
    end else begin
      state_q <= state_d;
      gp_q    <= gp_d;
    end
  end

  // Flush restarts recovery from any state, including mid-walk and the DONE cycle.
  always_comb begin
    state_d = state_q;
    gp_d    = gp_q;
    if (flush) begin
      state_d = S_DRAIN;
      gp_d    = '0;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_IDLE;
        S_DRAIN: if (!cmt_pending) state_d = S_WALK;
        S_WALK: begin
          if (gp_q == GP_LAST) begin
            state_d = S_DONE;
            gp_d    = '0;
          end else begin
            gp_d = gp_q + 1'b1;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    arat_raddr    = '0;
    srat_waddr    = '0;
    srat_wdata    = '0;
    srat_we       = '0;
    fl_reinit     = 1'b0;
    rec_done      = 1'b0;
    rec_stall_req = flush | (state_q != S_IDLE);
    case (state_q)
      S_WALK: begin
        srat_we = '1;
        for (int i = 0; i < W; i++) begin
          arat_raddr[i*LAW +: LAW] = (LAW'(gp_q) << P) | LAW'(i);
          srat_waddr[i*LAW +: LAW] = (LAW'(gp_q) << P) | LAW'(i);
          srat_wdata[i*PAW +: PAW] = arat_rdata[i*PAW +: PAW];
        end
      end
      S_DONE: begin
        fl_reinit = !flush;
        rec_done  = !flush;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rn_recover_seq.sv
// Bench for rn_recover_seq: two instances (2 and 1 entries/cycle) share flush/commit/reset
// stimulus and are checked every cycle against a phase-counting reference model.
module tb_rn_recover_seq;

  logic clk = 1'b0;
  logic rst, flush, cmt;
  always #5 clk = ~clk;

  // Instance A: 2 entries per cycle; instance B: 1 entry per cycle.
  logic [9:0]  raddr_a, waddr_a;
  logic [11:0] rdata_a, wdata_a;
  logic [1:0]  we_a;
  logic        reinit_a, done_a, stall_a;
  logic [4:0]  raddr_b, waddr_b;
  logic [5:0]  rdata_b, wdata_b;
  logic        we_b, reinit_b, done_b, stall_b;

  rn_recover_seq #(.CONFIG_P_RECOVER_WIDTH(1), .CONFIG_LRF_AW(5), .CONFIG_PRF_AW(6)) u_w2 (
    .clk(clk), .rst(rst), .flush(flush), .cmt_pending(cmt),
    .arat_raddr(raddr_a), .arat_rdata(rdata_a), .srat_waddr(waddr_a), .srat_wdata(wdata_a),
    .srat_we(we_a), .fl_reinit(reinit_a), .rec_done(done_a), .rec_stall_req(stall_a));

  rn_recover_seq #(.CONFIG_P_RECOVER_WIDTH(0), .CONFIG_LRF_AW(5), .CONFIG_PRF_AW(6)) u_w1 (
    .clk(clk), .rst(rst), .flush(flush), .cmt_pending(cmt),
    .arat_raddr(raddr_b), .arat_rdata(rdata_b), .srat_waddr(waddr_b), .srat_wdata(wdata_b),
    .srat_we(we_b), .fl_reinit(reinit_b), .rec_done(done_b), .rec_stall_req(stall_b));

  logic [5:0] arat [2][32];
  logic [5:0] srat [2][32];

  always_comb begin
    rdata_a = {arat[0][raddr_a[9:5]], arat[0][raddr_a[4:0]]};
    rdata_b = arat[1][raddr_b];
  end

  always @(posedge clk) begin
    if (we_a[0]) srat[0][waddr_a[4:0]] <= wdata_a[5:0];
    if (we_a[1]) srat[0][waddr_a[9:5]] <= wdata_a[11:6];
    if (we_b)    srat[1][waddr_b]      <= wdata_b;
  end

  int n_chk = 0, n_pass = 0;
  int cyc_n = 0;
  bit chk_en = 0;
  // Model phase: -1 idle, 0 draining, 1..NG walking group (phase-1), NG+1 done.
  int ph [2] = '{-1, -1};
  int first_re [2], first_we [2], cnt_re [2];
  int t0;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc_n);
  endtask

  task automatic check_outputs();
    for (int j = 0; j < 2; j++) begin
      int wn, ng, ea, ewd, o_ra, o_wa, o_wd;
      bit walk;
      string nm;
      wn   = (j == 0) ? 2 : 1;
      ng   = 32 / wn;
      nm   = (j == 0) ? "w2" : "w1";
      walk = (ph[j] >= 1) && (ph[j] <= ng);
      check({nm, "_stall"}, (j == 0) ? int'(stall_a) : int'(stall_b), int'(flush || ph[j] != -1));
      check({nm, "_we"}, (j == 0) ? int'(we_a) : int'(we_b), walk ? (1 << wn) - 1 : 0);
      check({nm, "_reinit"}, (j == 0) ? int'(reinit_a) : int'(reinit_b),
            int'(ph[j] == ng + 1 && !flush));
      check({nm, "_done"}, (j == 0) ? int'(done_a) : int'(done_b),
            int'(ph[j] == ng + 1 && !flush));
      for (int s = 0; s < wn; s++) begin
        ea  = walk ? (ph[j] - 1) * wn + s : 0;
        ewd = walk ? int'(arat[j][ea]) : 0;
        o_ra = (j == 0) ? int'(raddr_a[s*5 +: 5]) : int'(raddr_b);
        o_wa = (j == 0) ? int'(waddr_a[s*5 +: 5]) : int'(waddr_b);
        o_wd = (j == 0) ? int'(wdata_a[s*6 +: 6]) : int'(wdata_b);
        check($sformatf("%s_raddr%0d", nm, s), o_ra, ea);
        check($sformatf("%s_waddr%0d", nm, s), o_wa, ea);
        check($sformatf("%s_wdata%0d", nm, s), o_wd, ewd);
      end
    end
  endtask

  task automatic cyc(input bit f, input bit c, input bit r);
    @(negedge clk);
    flush = f; cmt = c; rst = r;
    #1;
    if (chk_en) check_outputs();
    if (reinit_a) begin cnt_re[0]++; if (first_re[0] < 0) first_re[0] = cyc_n; end
    if (reinit_b) begin cnt_re[1]++; if (first_re[1] < 0) first_re[1] = cyc_n; end
    if (we_a != 0 && first_we[0] < 0) first_we[0] = cyc_n;
    if (we_b && first_we[1] < 0) first_we[1] = cyc_n;
    @(posedge clk);
    for (int j = 0; j < 2; j++) begin
      int ng;
      ng = (j == 0) ? 16 : 32;
      if (r)                  ph[j] = -1;
      else if (f)             ph[j] = 0;
      else if (ph[j] == 0)    ph[j] = c ? 0 : 1;
      else if (ph[j] >= 1 && ph[j] <= ng) ph[j] = ph[j] + 1;
      else                    ph[j] = -1;
    end
    cyc_n++;
  endtask

  task automatic clear_marks();
    for (int j = 0; j < 2; j++) begin first_re[j] = -1; first_we[j] = -1; cnt_re[j] = 0; end
  endtask

  task automatic wait_ph0(input int target, input string tag);
    int g = 0;
    while (ph[0] != target && g < 100) begin cyc(0, 0, 0); g++; end
    check(tag, ph[0], target);
  endtask

  initial begin
    flush = 0; cmt = 0; rst = 1;
    for (int k = 0; k < 32; k++) begin
      arat[0][k] = 6'(k + 32); arat[1][k] = 6'(k + 32);
      srat[0][k] = '0;         srat[1][k] = '0;
    end
    clear_marks();
    cyc(0, 0, 1); cyc(0, 0, 1);
    chk_en = 1;
    cyc(0, 0, 0); cyc(0, 0, 0);

    // Full recovery with no commit backlog; latency to the re-init pulse.
    clear_marks(); t0 = cyc_n;
    cyc(1, 0, 0);
    repeat (40) cyc(0, 0, 0);
    check("lat_reinit_w2", first_re[0] - t0, 18);
    check("lat_reinit_w1", first_re[1] - t0, 34);
    check("lat_we_w2", first_we[0] - t0, 2);
    for (int k = 0; k < 32; k++) begin
      check($sformatf("srat_w2_%0d", k), int'(srat[0][k]), k + 32);
      check($sformatf("srat_w1_%0d", k), int'(srat[1][k]), k + 32);
    end

    // Commit backlog holds DRAIN.
    clear_marks(); t0 = cyc_n;
    cyc(1, 1, 0);
    repeat (5) cyc(0, 1, 0);
    repeat (40) cyc(0, 0, 0);
    check("drain_we_w2", first_we[0] - t0, 7);
    check("drain_we_w1", first_we[1] - t0, 7);

    // Re-flush mid-walk at group 7.
    for (int k = 0; k < 32; k++) begin arat[0][k] = 6'($urandom); arat[1][k] = 6'($urandom); end
    cyc(1, 0, 0);
    wait_ph0(8, "reach_gp7");
    clear_marks();
    cyc(1, 0, 0);
    repeat (45) cyc(0, 0, 0);
    check("reflush_reinit_w2", cnt_re[0], 1);
    check("reflush_reinit_w1", cnt_re[1], 1);
    for (int k = 0; k < 32; k++) check($sformatf("reflush_srat_w2_%0d", k), int'(srat[0][k]), int'(arat[0][k]));

    // Reset mid-walk.
    cyc(1, 0, 0);
    wait_ph0(6, "reach_gp5");
    clear_marks();
    cyc(0, 0, 1);
    repeat (40) cyc(0, 0, 0);
    check("rst_reinit_w2", cnt_re[0], 0);
    check("rst_reinit_w1", cnt_re[1], 0);

    // Flush in the DONE cycle.
    cyc(1, 0, 0);
    wait_ph0(17, "reach_done");
    clear_marks();
    cyc(1, 0, 0);
    repeat (40) cyc(0, 0, 0);
    check("done_flush_reinit_w2", cnt_re[0], 1);
    check("done_flush_reinit_w1", cnt_re[1], 1);

    // Random traffic.
    repeat (2000) begin
      if ($urandom_range(0, 9) == 0) arat[$urandom_range(0, 1)][$urandom_range(0, 31)] = 6'($urandom);
      cyc(($urandom_range(0, 29) == 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 399) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
